// File: rtl/card_7seg.sv
// Card-code to active-low 7-segment decoder for one board-display digit.
// Optionally registered (1-cycle latency) with an asynchronous blanking reset.
module card_7seg #(
    parameter int REGISTER_OUTPUT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] SW,
    output logic [6:0] HEX0
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [6:0] seg_next;

    // Unlisted codes and X/Z on SW fall through to the blank default.
    always_comb begin
        seg_next = SEG_BLANK;
        case (SW)
            4'd1:    seg_next = 7'b0001000;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            4'd10:   seg_next = 7'b1000000;
            4'd11:   seg_next = 7'b1100001;
            4'd12:   seg_next = 7'b0011000;
            4'd13:   seg_next = 7'b0001001;
            default: seg_next = SEG_BLANK;
        endcase
    end

    generate
        if (REGISTER_OUTPUT != 0) begin : g_reg
            logic [6:0] hex_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hex_reg <= SEG_BLANK;
                end else begin
                    hex_reg <= seg_next;
                end
            end

            assign HEX0 = hex_reg;
        end else begin : g_comb
            assign HEX0 = seg_next;
        end
    endgenerate

endmodule

// File: tb/tb_card_7seg.sv
// Directed bench for card_7seg: registered build plus a combinational build
// sharing the same SW stimulus.
module tb_card_7seg;

    logic       clk;
    logic       rst;
    logic [3:0] SW;
    logic [6:0] hex_reg_out;
    logic [6:0] hex_comb_out;

    int vectors;
    int miscompares;

    logic [6:0] exp_tab [16];

    card_7seg #(.REGISTER_OUTPUT(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .SW   (SW),
        .HEX0 (hex_reg_out)
    );

    card_7seg #(.REGISTER_OUTPUT(0)) dut_comb (
        .clk  (clk),
        .rst  (rst),
        .SW   (SW),
        .HEX0 (hex_comb_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        rst = 1'b1;
        SW  = 4'd8;
        #1;
        vectors++;
        if (hex_reg_out !== 7'b1111111) begin
            $display("FAIL reset_immediate: got %b required %b", hex_reg_out, 7'b1111111);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (hex_reg_out !== 7'b1111111) begin
            $display("FAIL reset_held: got %b required %b", hex_reg_out, 7'b1111111);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (hex_reg_out !== 7'b1111111) begin
            $display("FAIL reset_release_no_edge: got %b required %b", hex_reg_out, 7'b1111111);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (hex_reg_out !== 7'b0000000) begin
            $display("FAIL reset_first_edge: got %b required %b", hex_reg_out, 7'b0000000);
            miscompares++;
        end
        $display("reset: SW=8 HEX0=%b", hex_reg_out);
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            SW = 4'(i);
            #1;
            vectors++;
            if (hex_comb_out !== exp_tab[i]) begin
                $display("FAIL sweep_comb SW=%0d: got %b required %b", i, hex_comb_out, exp_tab[i]);
                miscompares++;
            end
            @(posedge clk); #1;
            vectors++;
            if (hex_reg_out !== exp_tab[i]) begin
                $display("FAIL sweep_reg SW=%0d: got %b required %b", i, hex_reg_out, exp_tab[i]);
                miscompares++;
            end
            $display("sweep: SW=%0d HEX0=%b", i, hex_reg_out);
        end
    endtask

    task automatic test_invalid;
        logic [3:0] codes [3];
        codes[0] = 4'd14;
        codes[1] = 4'd15;
        codes[2] = 4'd0;
        // Precede each blank code with a lit digit so a stuck output is caught.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            SW = 4'd8;
            @(negedge clk);
            SW = codes[i];
            @(posedge clk); #1;
            vectors++;
            if (hex_reg_out !== 7'b1111111) begin
                $display("FAIL invalid SW=%0d: got %b required %b", codes[i], hex_reg_out, 7'b1111111);
                miscompares++;
            end
            $display("invalid: SW=%0d HEX0=%b", codes[i], hex_reg_out);
        end
        @(negedge clk);
        SW = 4'bx;
        #1;
        vectors++;
        if (hex_comb_out !== 7'b1111111) begin
            $display("FAIL invalid_x_comb: got %b required %b", hex_comb_out, 7'b1111111);
            miscompares++;
        end
    endtask

    task automatic test_latency;
        @(negedge clk);
        SW = 4'd2;
        @(posedge clk); #1;
        vectors++;
        if (hex_reg_out !== 7'b0100100) begin
            $display("FAIL latency_start: got %b required %b", hex_reg_out, 7'b0100100);
            miscompares++;
        end
        @(negedge clk);
        SW = 4'd3;
        #1;
        vectors++;
        if (hex_reg_out !== 7'b0100100) begin
            $display("FAIL latency_hold: got %b required %b", hex_reg_out, 7'b0100100);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (hex_reg_out !== 7'b0110000) begin
            $display("FAIL latency_update: got %b required %b", hex_reg_out, 7'b0110000);
            miscompares++;
        end
        $display("latency: SW 2->3 HEX0=%b", hex_reg_out);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        SW = 4'd12;
        @(posedge clk); #1;
        vectors++;
        if (hex_reg_out !== 7'b0011000) begin
            $display("FAIL async_before: got %b required %b", hex_reg_out, 7'b0011000);
            miscompares++;
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (hex_reg_out !== 7'b1111111) begin
            $display("FAIL async_blank: got %b required %b", hex_reg_out, 7'b1111111);
            miscompares++;
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (hex_reg_out !== 7'b1111111) begin
            $display("FAIL async_release_hold: got %b required %b", hex_reg_out, 7'b1111111);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (hex_reg_out !== 7'b0011000) begin
            $display("FAIL async_recover: got %b required %b", hex_reg_out, 7'b0011000);
            miscompares++;
        end
        $display("async_reset: SW=12 HEX0=%b", hex_reg_out);
    endtask

    task automatic test_comb;
        @(posedge clk); #1;
        SW = 4'd7;
        #1;
        vectors++;
        if (hex_comb_out !== 7'b1111000) begin
            $display("FAIL comb_zero_latency: got %b required %b", hex_comb_out, 7'b1111000);
            miscompares++;
        end
        SW = 4'd11;
        #1;
        vectors++;
        if (hex_comb_out !== 7'b1100001) begin
            $display("FAIL comb_jack: got %b required %b", hex_comb_out, 7'b1100001);
            miscompares++;
        end
        $display("comb: SW=11 HEX0=%b", hex_comb_out);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_tab[0]  = 7'b1111111;
        exp_tab[1]  = 7'b0001000;
        exp_tab[2]  = 7'b0100100;
        exp_tab[3]  = 7'b0110000;
        exp_tab[4]  = 7'b0011001;
        exp_tab[5]  = 7'b0010010;
        exp_tab[6]  = 7'b0000010;
        exp_tab[7]  = 7'b1111000;
        exp_tab[8]  = 7'b0000000;
        exp_tab[9]  = 7'b0010000;
        exp_tab[10] = 7'b1000000;
        exp_tab[11] = 7'b1100001;
        exp_tab[12] = 7'b0011000;
        exp_tab[13] = 7'b0001001;
        exp_tab[14] = 7'b1111111;
        exp_tab[15] = 7'b1111111;
        rst = 1'b0;
        SW  = 4'd0;
        #2;

        test_reset();
        test_sweep();
        test_invalid();
        test_latency();
        test_async_reset();
        test_comb();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
